// File: rtl/intc_nested.sv
// ---------------------------------------------------------------------------
// intc_nested: nested, fixed-priority interrupt controller.
// - Synchronises NUM_IRQ asynchronous request lines and latches their rising
//   edges as pending requests.
// - Applies a per-line mask and a global enable, then picks the lowest
//   eligible line as the winner.
// - Keeps an EPC/priority stack, so a higher-priority request can preempt a
//   running handler. eret pops the stack.
// Optional build macro: INTC_VECTORED_EN. When it is defined, each line gets
// its own handler entrance. When it is undefined, all lines share VEC_BASE.
// ---------------------------------------------------------------------------
module intc_nested #(
  parameter int                NUM_IRQ    = 3,
  parameter int                ADDR_W     = 32,
  parameter int                NEST_DEPTH = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(32'h0000_0300),
  parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(32'h0000_0040),
  localparam int CW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  localparam int DW = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [ADDR_W-1:0]  pc_next,
  input  logic               eret,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               gie_we,
  input  logic               gie_wdata,
  output logic               take,
  output logic [ADDR_W-1:0]  entrance,
  output logic [CW-1:0]      cause_id,
  output logic [ADDR_W-1:0]  ret_pc,
  output logic [NUM_IRQ-1:0] pending,
  output logic [DW-1:0]      depth,
  output logic               stack_err
);

  // Stack index width, and the priority width that can also hold NUM_IRQ
  // (the "idle" priority that every line beats).
  localparam int IW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam int PW = $clog2(NUM_IRQ + 1);

  logic [NUM_IRQ-1:0] sync1, sync2, hist;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] mask;
  logic               gie;
  logic [ADDR_W-1:0]  epc_stk [NEST_DEPTH];
  logic [CW-1:0]      pri_stk [NEST_DEPTH];

  logic [IW-1:0]      top_idx, push_idx;
  logic               stack_empty, stack_full;
  logic [PW-1:0]      cur_pri;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [CW-1:0]      win;
  logic               found;

  // Two-flop synchroniser per line, followed by a history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      // NOTE: non-blocking assignments make the chain shift by exactly one
      // stage per clock. Blocking assignments would collapse it into a wire.
      sync1 <= irq_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

  // Decode the top of the stack and the priority level of the handler that is running.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    top_idx     = IW'(depth - 1'b1);
    push_idx    = IW'(depth);
    stack_empty = (depth == '0);
    stack_full  = (depth == DW'(NEST_DEPTH));
    cur_pri     = PW'(NUM_IRQ);
    ret_pc      = '0;
    if (!stack_empty) begin
      cur_pri = PW'(pri_stk[top_idx]);
      ret_pc  = epc_stk[top_idx];
    end
  end

  // Eligibility and fixed-priority winner (the lowest index wins).
  always_comb begin
    eligible = '0;
    win      = '0;
    found    = 1'b0;
    clr_vec  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      eligible[i] = pending[i] & ~mask[i] & gie & (PW'(i) < cur_pri) & ~stack_full;
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i] && !found) begin
        win   = CW'(i);
        found = 1'b1;
      end
    end
    // eret has precedence. A take that collides with it waits one cycle.
    take = found & ~eret;
    if (take) clr_vec[win] = 1'b1;
  end

  assign cause_id = win;

`ifdef INTC_VECTORED_EN
  assign entrance = VEC_BASE + ADDR_W'(win) * VEC_STRIDE;
`else
  assign entrance = VEC_BASE;
`endif

  // Pending latch. A new edge on a line wins over a clear from a take on that line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_vec) | rise;
  end

  // Software-visible mask and global enable registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
      gie  <= 1'b1;
    end else begin
      if (mask_we) mask <= mask_wdata;
      if (gie_we)  gie  <= gie_wdata;
    end
  end

  // EPC/priority stack. A take pushes, an eret pops (the two never happen together).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the stack storage is cleared on reset, so ret_pc and cur_pri
      // never expose stale entries from before the reset.
      for (int i = 0; i < NEST_DEPTH; i++) begin
        epc_stk[i] <= '0;
        pri_stk[i] <= '0;
      end
      depth <= '0;
    end else if (take) begin
      epc_stk[push_idx] <= pc_next;
      pri_stk[push_idx] <= win;
      depth             <= depth + 1'b1;
    end else if (eret && !stack_empty) begin
      depth <= depth - 1'b1;
    end
  end

  // Sticky flag: an eret arrived while no handler was active (stack underflow).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      stack_err <= 1'b0;
    else if (eret && stack_empty) stack_err <= 1'b1;
  end

endmodule

// File: tb/tb_intc_nested.sv
// ---------------------------------------------------------------------------
// tb_intc_nested: table-driven bench for intc_nested (NEST_DEPTH = 2).
// Each table row is applied just after a falling edge. The outputs are
// compared 1 ns later, before the next rising edge.
// ---------------------------------------------------------------------------
module tb_intc_nested;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq_in;
  logic [31:0] pc_next;
  logic        eret, mask_we, gie_we, gie_wdata;
  logic [2:0]  mask_wdata;
  logic        take, stack_err;
  logic [31:0] entrance, ret_pc;
  logic [1:0]  cause_id, depth;
  logic [2:0]  pending;

  int checks = 0;
  int errors = 0;

  intc_nested #(.NUM_IRQ(3), .ADDR_W(32), .NEST_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .pc_next(pc_next), .eret(eret),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .gie_we(gie_we),
    .gie_wdata(gie_wdata), .take(take), .entrance(entrance),
    .cause_id(cause_id), .ret_pc(ret_pc), .pending(pending), .depth(depth),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  irq;
    logic [31:0] pc;
    logic        eret, mwe;
    logic [2:0]  mdata;
    logic        gwe, gdata;
    logic        take;
    logic [1:0]  cause;
    logic [2:0]  pend;
    logic [1:0]  dep;
    logic [31:0] ret;
    logic        err;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] exp_entrance(input logic [1:0] id);
`ifdef INTC_VECTORED_EN
    logic [31:0] idw;
    idw = {30'd0, id};
    return 32'h0000_0300 + idw * 32'h0000_0040;
`else
    return (id == 2'd3) ? 32'h0000_0300 : 32'h0000_0300;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] irq, input logic [31:0] pc, input logic er,
                     input logic mwe, input logic [2:0] md, input logic gwe,
                     input logic gd, input logic tk, input logic [1:0] cs,
                     input logic [2:0] pd, input logic [1:0] dp,
                     input logic [31:0] rp, input logic se);
    vec_t v;
    v.irq = irq; v.pc = pc; v.eret = er; v.mwe = mwe; v.mdata = md;
    v.gwe = gwe; v.gdata = gd; v.take = tk; v.cause = cs; v.pend = pd;
    v.dep = dp; v.ret = rp; v.err = se;
    vq.push_back(v);
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; pc_next = '0; eret = 0;
    mask_we = 0; mask_wdata = '0; gie_we = 0; gie_wdata = 0;

    // Columns: irq, pc_next, eret, mask_we, mask_wdata, gie_we, gie_wdata |
    //          take, cause, pending, depth, ret_pc, stack_err
    // Line 2 held high: take on the 4th row, then exactly once.
    add(3'b100, 32'h40,  0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0); // 0
    add(3'b100, 32'h40,  0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0);
    add(3'b100, 32'h40,  0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0);
    add(3'b100, 32'h40,  0,0,3'b000,0,0, 1,2,3'b100,0,32'h0,  0); // 3
    add(3'b100, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,1,32'h40, 0);
    add(3'b100, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,1,32'h40, 0);
    // Line 0 pulse preempts line 2.
    add(3'b101, 32'h384, 0,0,3'b000,0,0, 0,0,3'b000,1,32'h40, 0); // 6
    add(3'b100, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,1,32'h40, 0);
    add(3'b100, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,1,32'h40, 0);
    add(3'b100, 32'h384, 0,0,3'b000,0,0, 1,0,3'b001,1,32'h40, 0); // 9
    add(3'b100, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,2,32'h384,0);
    add(3'b100, 32'h0,   1,0,3'b000,0,0, 0,0,3'b000,2,32'h384,0);
    add(3'b100, 32'h0,   1,0,3'b000,0,0, 0,0,3'b000,1,32'h40, 0); // 12
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0);
    // Line 0 active; a line 1 pulse must wait for the return.
    add(3'b001, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0); // 14
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0);
    add(3'b000, 32'h500, 0,0,3'b000,0,0, 1,0,3'b001,0,32'h0,  0); // 17
    add(3'b010, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,1,32'h500,0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,1,32'h500,0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,1,32'h500,0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b010,1,32'h500,0); // 21
    add(3'b000, 32'h0,   1,0,3'b000,0,0, 0,0,3'b010,1,32'h500,0);
    add(3'b000, 32'h600, 0,0,3'b000,0,0, 1,1,3'b010,0,32'h0,  0); // 23
    add(3'b000, 32'h0,   1,0,3'b000,0,0, 0,0,3'b000,1,32'h600,0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0);
    // Mask blocks line 0 but keeps its pending bit.
    add(3'b000, 32'h0,   0,1,3'b001,0,0, 0,0,3'b000,0,32'h0,  0); // 26
    add(3'b001, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b001,0,32'h0,  0); // 30
    add(3'b000, 32'h0,   0,1,3'b000,0,0, 0,0,3'b001,0,32'h0,  0);
    add(3'b000, 32'h700, 0,0,3'b000,0,0, 1,0,3'b001,0,32'h0,  0); // 32
    add(3'b000, 32'h0,   1,0,3'b000,0,0, 0,0,3'b000,1,32'h700,0);
    // gie = 0 blocks every line.
    add(3'b000, 32'h0,   0,0,3'b000,1,0, 0,0,3'b000,0,32'h0,  0); // 34
    add(3'b100, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b100,0,32'h0,  0); // 38
    add(3'b000, 32'h0,   0,0,3'b000,1,1, 0,0,3'b100,0,32'h0,  0);
    add(3'b000, 32'h800, 0,0,3'b000,0,0, 1,2,3'b100,0,32'h0,  0); // 40
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,1,32'h800,0);
    // Fill the stack (2 then 1). Line 0 is held off while the stack is full.
    add(3'b010, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,1,32'h800,0); // 42
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,1,32'h800,0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,1,32'h800,0);
    add(3'b000, 32'h900, 0,0,3'b000,0,0, 1,1,3'b010,1,32'h800,0); // 45
    add(3'b001, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,2,32'h900,0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,2,32'h900,0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,2,32'h900,0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b001,2,32'h900,0); // 49
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b001,2,32'h900,0);
    add(3'b000, 32'h0,   1,0,3'b000,0,0, 0,0,3'b001,2,32'h900,0);
    add(3'b000, 32'h0,   1,0,3'b000,0,0, 0,0,3'b001,1,32'h800,0); // 52: eret wins
    add(3'b000, 32'hA00, 0,0,3'b000,0,0, 1,0,3'b001,0,32'h0,  0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,1,32'hA00,0);
    // Return, then an underflowing eret.
    add(3'b000, 32'h0,   1,0,3'b000,0,0, 0,0,3'b000,1,32'hA00,0); // 55
    add(3'b000, 32'h0,   1,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  0);
    add(3'b000, 32'h0,   0,0,3'b000,0,0, 0,0,3'b000,0,32'h0,  1); // 57

    // Outputs while reset is held.
    #1;
    check("reset take",     {31'd0, take},      32'd0);
    check("reset cause",    {30'd0, cause_id},  32'd0);
    check("reset entrance", entrance,           32'h300);
    check("reset ret_pc",   ret_pc,             32'd0);
    check("reset pending",  {29'd0, pending},   32'd0);
    check("reset depth",    {30'd0, depth},     32'd0);
    check("reset err",      {31'd0, stack_err}, 32'd0);

    foreach (vq[i]) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      irq_in = vq[i].irq; pc_next = vq[i].pc; eret = vq[i].eret;
      mask_we = vq[i].mwe; mask_wdata = vq[i].mdata;
      gie_we = vq[i].gwe; gie_wdata = vq[i].gdata;
      #1;
      check($sformatf("v%0d take", i),     {31'd0, take},      {31'd0, vq[i].take});
      check($sformatf("v%0d cause", i),    {30'd0, cause_id},  {30'd0, vq[i].cause});
      check($sformatf("v%0d entrance", i), entrance,           exp_entrance(vq[i].cause));
      check($sformatf("v%0d pending", i),  {29'd0, pending},   {29'd0, vq[i].pend});
      check($sformatf("v%0d depth", i),    {30'd0, depth},     {30'd0, vq[i].dep});
      check($sformatf("v%0d ret_pc", i),   ret_pc,             vq[i].ret);
      check($sformatf("v%0d err", i),      {31'd0, stack_err}, {31'd0, vq[i].err});
    end

    // Simultaneous edges on all lines: line 0 is taken first, the others stay pending.
    @(negedge clk); irq_in = 3'b111; pc_next = 32'hB00; eret = 0;
    mask_we = 0; gie_we = 0;
    @(negedge clk); irq_in = 3'b000;
    @(negedge clk);
    @(negedge clk); #1;
    check("simul pending", {29'd0, pending}, 32'h7);
    check("simul take",    {31'd0, take},    32'd1);
    check("simul cause",   {30'd0, cause_id}, 32'd0);
    @(negedge clk); #1;
    check("simul depth",   {30'd0, depth},   32'd1);
    check("simul pend2",   {29'd0, pending}, 32'h6);
    check("simul no take", {31'd0, take},    32'd0);
    check("simul ret_pc",  ret_pc,           32'hB00);

    // Asynchronous reset in the middle of the handler.
    #2 rst = 1'b1;
    #1;
    check("midrst depth",    {30'd0, depth},     32'd0);
    check("midrst pending",  {29'd0, pending},   32'd0);
    check("midrst err",      {31'd0, stack_err}, 32'd0);
    check("midrst take",     {31'd0, take},      32'd0);
    check("midrst ret_pc",   ret_pc,             32'd0);
    check("midrst entrance", entrance,           32'h300);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check("post rst take",    {31'd0, take},    32'd0);
    check("post rst pending", {29'd0, pending}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
